// File: rtl/cell_histogram.sv
// cell_histogram: streaming HOG cell-histogram accumulator.
// Sums gradient magnitudes into NUM_BINS per-bin accumulators over
// CELL_PIXELS valid samples. Each completed cell is published as one packed
// word with a single-cycle valid pulse.
module cell_histogram #(
    parameter int MAG_W       = 8,
    parameter int NUM_BINS    = 9,
    parameter int BIN_W       = 4,
    parameter int CELL_PIXELS = 64,
    parameter int ACC_W       = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      i_valid,
    input  logic [BIN_W-1:0]          i_bin,
    input  logic [MAG_W-1:0]          i_mag,
    output logic [NUM_BINS*ACC_W-1:0] o_hist,
    output logic                      o_valid,
    output logic                      o_bin_err
);

    localparam int CNT_W = $clog2(CELL_PIXELS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CELL_PIXELS - 1);
    // One extra bit so NUM_BINS == 2^BIN_W is still representable.
    localparam logic [BIN_W:0] BIN_LIMIT = NUM_BINS[BIN_W:0];

    logic [CNT_W-1:0]                    cnt;
    logic [NUM_BINS-1:0][ACC_W-1:0]      acc;
    logic [NUM_BINS-1:0][ACC_W-1:0]      acc_next;
    logic [ACC_W-1:0]                    mag_ext;
    logic                                bin_ok;
    logic                                last;

    assign mag_ext = ACC_W'(i_mag);
    assign bin_ok  = ({1'b0, i_bin} < BIN_LIMIT);
    assign last    = (cnt == LAST_CNT);

    // Next accumulator values for a valid sample; the first sample of a
    // cell overwrites all bins so no separate clearing cycle is needed.
    always_comb begin
        acc_next = acc;
        for (int unsigned k = 0; k < NUM_BINS; k++) begin
            if (cnt == '0) begin
                acc_next[k] = (bin_ok && i_bin == k[BIN_W-1:0]) ? mag_ext : '0;
            end else if (bin_ok && i_bin == k[BIN_W-1:0]) begin
                acc_next[k] = acc[k] + mag_ext;
            end
        end
    end

    // Sample counter, accumulators, output register and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            o_hist    <= '0;
            o_valid   <= 1'b0;
            o_bin_err <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            acc       <= '0;
            o_valid   <= 1'b0;
            o_bin_err <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_valid) begin
                acc <= acc_next;
                cnt <= last ? '0 : cnt + 1'b1;
                if (!bin_ok) begin
                    o_bin_err <= 1'b1;
                end
                // Publish from acc_next so the final sample is included.
                if (last) begin
                    o_hist  <= acc_next;
                    o_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cell_histogram.sv
// tb_cell_histogram: directed self-checking bench for cell_histogram with a
// reference model and a scoreboard queue of expected histograms.
module tb_cell_histogram;

    localparam int MAG_W = 8;
    localparam int NB    = 9;
    localparam int BIN_W = 4;
    localparam int CP    = 64;
    localparam int AW    = 14;
    localparam int HW    = NB * AW;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              i_valid;
    logic [BIN_W-1:0]  i_bin;
    logic [MAG_W-1:0]  i_mag;
    logic [HW-1:0]     o_hist;
    logic              o_valid;
    logic              o_bin_err;

    cell_histogram #(
        .MAG_W(MAG_W), .NUM_BINS(NB), .BIN_W(BIN_W),
        .CELL_PIXELS(CP), .ACC_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .i_valid(i_valid),
        .i_bin(i_bin), .i_mag(i_mag), .o_hist(o_hist),
        .o_valid(o_valid), .o_bin_err(o_bin_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            pulses   = 0;
    int            mcnt;
    int            macc [NB];
    logic          merr;
    logic          exp_v;
    logic [HW-1:0] exp_hist;
    logic [HW-1:0] sb [$];

    task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        mcnt = 0;
        for (int k = 0; k < NB; k++) macc[k] = 0;
    endtask

    // Drive one cycle at the falling edge, update the model, then check all
    // outputs at the next falling edge.
    task automatic step(input logic v, input logic c, input logic [BIN_W-1:0] b,
                        input logic [MAG_W-1:0] m);
        logic [HW-1:0] h;
        logic [HW-1:0] got;
        i_valid = v; clear = c; i_bin = b; i_mag = m;
        exp_v = 1'b0;
        if (c) begin
            model_zero();
            merr = 1'b0;
        end else if (v) begin
            if (mcnt == 0) for (int k = 0; k < NB; k++) macc[k] = 0;
            if (int'(b) < NB) macc[b] += int'(m);
            else merr = 1'b1;
            mcnt++;
            if (mcnt == CP) begin
                mcnt = 0;
                h = '0;
                for (int k = 0; k < NB; k++) h[k*AW +: AW] = macc[k][AW-1:0];
                sb.push_back(h);
                exp_hist = h;
                exp_v = 1'b1;
            end
        end
        @(negedge clk);
        chk("o_valid", HW'(o_valid), HW'(exp_v));
        if (o_valid === 1'b1) begin
            pulses++;
            chk("sb_nonempty", HW'(sb.size() != 0), HW'(1));
            if (sb.size() != 0) begin
                got = sb.pop_front();
                chk("o_hist_sb", o_hist, got);
            end
        end
        chk("o_hist_hold", o_hist, exp_hist);
        chk("o_bin_err", HW'(o_bin_err), HW'(merr));
    endtask

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; clear = 1'b0; i_bin = '0; i_mag = '0;
        @(negedge clk);
        rst = 1'b0;
        model_zero();
        merr = 1'b0;
        exp_hist = '0;
        sb.delete();
        chk("rst_o_hist", o_hist, '0);
        chk("rst_o_valid", HW'(o_valid), '0);
        chk("rst_o_bin_err", HW'(o_bin_err), '0);
    endtask

    function automatic logic [AW-1:0] bin_of(input logic [HW-1:0] h, input int k);
        return h[k*AW +: AW];
    endfunction

    initial begin
        rst = 1'b1; clear = 1'b0; i_valid = 1'b0; i_bin = '0; i_mag = '0;
        @(negedge clk);
        do_reset();

        // Uniform fill into bin 3.
        for (int i = 0; i < CP; i++) step(1'b1, 1'b0, 4'd3, 8'd1);
        chk("uniform_bin3", HW'(bin_of(o_hist, 3)), HW'(64));
        chk("uniform_bin0", HW'(bin_of(o_hist, 0)), HW'(0));
        step(1'b0, 1'b0, 4'd0, 8'd0);

        // Maximum magnitude into bin 8, then idle while o_hist must hold.
        for (int i = 0; i < CP; i++) step(1'b1, 1'b0, 4'd8, 8'd255);
        chk("maxmag_bin8", HW'(bin_of(o_hist, 8)), HW'(16320));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd0, 8'd0);
        chk("maxmag_hold", HW'(bin_of(o_hist, 8)), HW'(16320));

        // Back-to-back cells, second one with alternating valid gaps.
        pulses = 0;
        for (int i = 0; i < CP; i++) step(1'b1, 1'b0, BIN_W'(i % 8), 8'd2);
        chk("cellA_bin0", HW'(bin_of(o_hist, 0)), HW'(16));
        chk("cellA_bin7", HW'(bin_of(o_hist, 7)), HW'(16));
        chk("cellA_bin8", HW'(bin_of(o_hist, 8)), HW'(0));
        for (int i = 0; i < 2*CP; i++) step((i % 2) == 0, 1'b0, 4'd0, 8'd5);
        step(1'b0, 1'b0, 4'd0, 8'd0);
        chk("cellB_bin0", HW'(bin_of(o_hist, 0)), HW'(320));
        chk("cellB_bin1", HW'(bin_of(o_hist, 1)), HW'(0));
        chk("b2b_pulses", HW'(pulses), HW'(2));

        // Clear mid-cell with a valid sample in the clear cycle.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'd2, 8'd100);
        step(1'b1, 1'b1, 4'd2, 8'd50);
        for (int i = 0; i < CP; i++) step(1'b1, 1'b0, 4'd1, 8'd1);
        chk("clear_bin1", HW'(bin_of(o_hist, 1)), HW'(64));
        chk("clear_bin2", HW'(bin_of(o_hist, 2)), HW'(0));
        chk("clear_err", HW'(o_bin_err), HW'(0));

        // Out-of-range bin as the final sample of a cell.
        for (int i = 0; i < CP-1; i++) step(1'b1, 1'b0, 4'd4, 8'd3);
        step(1'b1, 1'b0, 4'd12, 8'd200);
        chk("badbin_bin4", HW'(bin_of(o_hist, 4)), HW'(189));
        chk("badbin_err", HW'(o_bin_err), HW'(1));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 8'd0);
        chk("badbin_sticky", HW'(o_bin_err), HW'(1));
        step(1'b0, 1'b1, 4'd0, 8'd0);
        chk("badbin_cleared", HW'(o_bin_err), HW'(0));

        // Reset mid-cell, then one random cell.
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 4'd5, 8'd7);
        do_reset();
        pulses = 0;
        for (int i = 0; i < CP; i++)
            step(1'b1, 1'b0, BIN_W'($urandom_range(NB-1, 0)), MAG_W'($urandom_range(255, 0)));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 8'd0);
        chk("rst_cell_pulses", HW'(pulses), HW'(1));
        chk("sb_empty", HW'(sb.size()), HW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cell_histogram.md
# cell_histogram

Streaming HOG cell-histogram accumulator. It consumes one (orientation bin, gradient magnitude) pair per valid cycle and sums the magnitudes into NUM_BINS per-bin accumulators over CELL_PIXELS valid samples. When a cell is complete it emits the full histogram as one packed word with a single-cycle valid pulse. It sits directly upstream of the histogram delay buffer, and its o_hist/o_valid drive that buffer's i_data/i_valid.

## Interface
- MAG_W, 8, gradient magnitude width (unsigned)
- NUM_BINS, 9, orientation bins per histogram
- BIN_W, 4, bin index width; must satisfy 2^BIN_W >= NUM_BINS
- CELL_PIXELS, 64, valid samples per cell; must be >= 2
- ACC_W, 14, per-bin accumulator width; must be >= MAG_W + clog2(CELL_PIXELS)

- clk  input  1  the clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous abort of the current cell
- i_valid  input  1  i_bin/i_mag valid this cycle
- i_bin  input  BIN_W  orientation bin index, 0..NUM_BINS-1
- i_mag  input  MAG_W  gradient magnitude
- o_hist  output  NUM_BINS*ACC_W  packed histogram; bin k in bits [k*ACC_W +: ACC_W]
- o_valid  output  1  one-cycle pulse: o_hist holds a new complete cell
- o_bin_err  output  1  sticky: an out-of-range i_bin was received

## Operation
- Registers:
  - sample counter cnt, range 0..CELL_PIXELS-1
  - NUM_BINS working accumulators acc[k]
  - output register o_hist, separate from acc
- Each cycle with i_valid=1 and clear=0:
  - If cnt==0: acc[k] <= (k==i_bin) ? i_mag : 0. The cell starts fresh with no extra cycle.
  - Otherwise acc[i_bin] <= acc[i_bin] + i_mag, zero-extended to ACC_W. Other bins hold.
  - cnt increments. At CELL_PIXELS-1 it wraps to 0.
- Cell completion (i_valid=1, cnt==CELL_PIXELS-1):
  - The next cycle, o_hist equals the final sums, including the last sample's contribution, and o_valid=1.
- o_hist holds its value until the next completion, even if clear is asserted.
- Cycles with i_valid=0 change nothing.
- Out-of-range bin (i_bin >= NUM_BINS) with i_valid=1:
  - The sample is counted in cnt.
  - Its magnitude is discarded; no accumulator changes.
  - o_bin_err is set.
- o_bin_err clears only on rst or clear.
- Accumulators never overflow, given the ACC_W constraint. There is no saturation logic.
- clear=1:
  - Next cycle, cnt=0 and all acc=0.
  - o_valid=0, even if the same cycle would have completed a cell.
  - o_bin_err=0.
  - i_valid in that cycle is ignored.
- Priority: rst > clear > i_valid.

## Timing
- Reset values: o_hist=0, o_valid=0, o_bin_err=0, cnt=0, all acc=0.
- Latency: o_valid rises exactly 1 cycle after the clock edge that samples the CELL_PIXELS-th valid input.
- Throughput: one sample per cycle. Back-to-back cells need no bubble; the first sample of cell n+1 may arrive in the same cycle o_valid pulses for cell n.
- No backpressure. The downstream buffer accepts every o_valid.
- o_valid is never high for two consecutive cycles. The minimum spacing is CELL_PIXELS cycles.
- rst mid-cell: the partial cell is discarded. The next CELL_PIXELS valid samples form a complete cell.
- Gaps in i_valid, of any length or pattern, do not affect the sums or the number of samples counted.

## Test plan
- Uniform fill: 64 consecutive samples, bin=3, mag=1 -> one cycle after the last, o_valid=1 for 1 cycle, bin3=64, all other bins 0.
- Max magnitude: 64 samples, bin=8, mag=255 -> bin8=16320, no wrap; o_hist stays stable until the next cell.
- Back-to-back with gaps:
  - Cell A: 64 samples cycling bins 0..7 at mag=2 -> bins0-7=16, bin8=0.
  - Cell B follows immediately, all bin 0, mag=5, i_valid toggling every other cycle -> bin0=320, others 0.
  - Exactly two o_valid pulses.
- Clear mid-cell: 10 samples at bin2 mag=100, then clear with i_valid=1, then 64 samples bin1 mag=1 -> bin1=64, bin2=0; o_bin_err=0.
- Bad bin: 63 samples at bin4 mag=3, plus 1 sample at bin=12 mag=200 -> o_valid fires, bin4=189, o_bin_err=1 stays set until clear.
- Reset mid-cell: 30 samples, then rst for 1 cycle -> all outputs 0. The next 64 samples produce exactly one correct histogram.
